led_cube_axil_regs: RTL
=======================

LED_CUBE_AXIL_REGS -- requirements
Module: led_cube_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 word slots).
REQ-003 SHALL have one clock and a synchronous, active-high reset (already decided): s00_axi_aclk  in  1  sole clock, all logic on rising edge; s00_axi_areset  in  1  synchronous active-high reset.
REQ-004 SHALL have s00_axi_awaddr  in  ADDR_W  write address; s00_axi_awprot  in  3  ignored; s00_axi_awvalid  in  1; s00_axi_awready  out  1.
REQ-005 SHALL have s00_axi_wdata  in  32; s00_axi_wstrb  in  4  byte enables; s00_axi_wvalid  in  1; s00_axi_wready  out  1.
REQ-006 SHALL have s00_axi_bresp  out  2; s00_axi_bvalid  out  1; s00_axi_bready  in  1.
REQ-007 SHALL have s00_axi_araddr  in  ADDR_W; s00_axi_arprot  in  3  ignored; s00_axi_arvalid  in  1; s00_axi_arready  out  1.
REQ-008 SHALL have s00_axi_rdata  out  32; s00_axi_rresp  out  2; s00_axi_rvalid  out  1; s00_axi_rready  in  1.
REQ-009 SHALL have reg0_o..reg3_o  out  32 each  current register contents to LED driver; reg_wr_pulse_o  out  4  one-cycle pulse per register written.

Function
REQ-010 SHALL decode word index = addr[ADDR_W-1:2]; indices 0-3 map to reg0-reg3 (offsets 0x0,0x4,0x8,0xC), all read/write; indices 4-7 unmapped; addr[1:0] ignored.
REQ-011 SHALL accept AW and W independently: awready=1 iff no AW held and bvalid=0; wready=1 iff no W held and bvalid=0; each captured on valid&ready.
REQ-012 SHALL perform the register write in the cycle after both AW and W are held (including both captured same cycle), clear both holds, and assert bvalid on that same edge.
REQ-013 SHALL apply wstrb per byte; bytes with strobe 0 keep their old value; wstrb=0 performs no change but still completes with a response.
REQ-014 SHALL hold bvalid and bresp stable until bready=1; bvalid clears on the edge where bvalid&bready; no new AW/W accepted while bvalid=1.
REQ-015 SHALL pulse reg_wr_pulse_o[n] for exactly one cycle, coincident with the register update, only for mapped index n with nonzero wstrb.
REQ-016 SHALL drive arready=1 iff rvalid=0; on arvalid&arready, register rdata/rresp and set rvalid on the next edge (1-cycle latency).
REQ-017 SHALL hold rdata, rresp and rvalid stable until rready=1; rvalid clears on rvalid&rready; back-to-back reads therefore sustain one read per 2 cycles.
REQ-018 SHALL return the pre-write value when a read and a write to the same register resolve on the same edge.
REQ-019 SHALL run read and write paths concurrently and independently.
REQ-020 SHALL drive bresp/rresp = 2'b00 (OKAY) for all mapped accesses.

Reset
REQ-021 SHALL, while s00_axi_areset=1 at a rising edge, clear reg0-reg3 to 0x00000000, drop any held AW/W, and drive awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, reg_wr_pulse_o=0.
REQ-022 SHALL abandon any in-flight transaction on reset with no response issued; ready signals take their REQ-011/REQ-016 values from the first cycle after reset deasserts.

Configuration
REQ-023 SHALL, when macro LED_CUBE_AXIL_SLVERR_EN is defined, respond to unmapped indices 4-7 with bresp/rresp = 2'b10 (SLVERR), rdata=0, no register change.
REQ-024 SHALL, when LED_CUBE_AXIL_SLVERR_EN is undefined, respond to unmapped indices with OKAY, rdata=0, writes silently discarded.

Verification
REQ-025 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read same -> reads return 0x1..0x4, resp OKAY, reg0_o..reg3_o match, one reg_wr_pulse_o pulse each.
REQ-026 Write 0xAABBCCDD to 0x8 with wstrb=4'b0101 over reg2=0x11223344 -> reg2=0x11BB33DD.
REQ-027 Present W two cycles before AW, hold bready=0 for 5 cycles -> bvalid asserted 1 cycle after AW capture, stable 5 cycles, awready/wready low until handshake.
REQ-028 Read/write to 0x14 -> SLVERR with macro, OKAY and rdata=0 without; reg0-reg3 unchanged.
REQ-029 Assert s00_axi_areset for 1 cycle with bvalid pending and reg1=0x5 -> bvalid=0, reg1=0, next fresh write completes normally.

Source files
------------

// File: rtl/led_cube_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit LED cube control registers with per-register write pulses.
// Define LED_CUBE_AXIL_SLVERR_EN to answer unmapped word slots 4-7 with SLVERR instead of OKAY.
module led_cube_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    output logic [3:0]                      reg_wr_pulse_o
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    logic [DW-1:0]    regs_q [4];
    logic [DW-1:0]    regs_d [4];
    logic             aw_held_q, aw_held_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic             w_held_q, w_held_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [3:0]       pulse_q, pulse_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             arready_q, arready_d;
    logic [IDX_W-1:0] ar_idx_s;
    logic             unused_s;

    function automatic logic is_mapped(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(4);
    endfunction

    function automatic logic [1:0] resp_for(input logic [IDX_W-1:0] idx);
`ifdef LED_CUBE_AXIL_SLVERR_EN
        return is_mapped(idx) ? 2'b00 : 2'b10;
`else
        return (idx == idx) ? 2'b00 : 2'b00;
`endif
    endfunction

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign ar_idx_s = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_s = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Next-state for write holds, register file, write response and read channel.
    always_comb begin
        regs_d    = regs_q;
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        pulse_d   = 4'b0000;

        if (s00_axi_awvalid && awready_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        end else begin
            aw_held_d = aw_held_q;
        end

        if (s00_axi_wvalid && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = s00_axi_wdata;
            wstrb_d  = s00_axi_wstrb;
        end else begin
            w_held_d = w_held_q;
        end

        // Both halves held: commit, release holds and raise the response together.
        if (aw_held_q && w_held_q) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = resp_for(aw_idx_q);
            if (is_mapped(aw_idx_q) && (wstrb_q != {SW{1'b0}})) begin
                regs_d[aw_idx_q[1:0]]  = merge_bytes(regs_q[aw_idx_q[1:0]], wdata_q, wstrb_q);
                pulse_d[aw_idx_q[1:0]] = 1'b1;
            end else begin
                pulse_d = 4'b0000;
            end
        end else if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        // Read data comes from the pre-update register file, so a same-edge write is not visible.
        if (s00_axi_arvalid && arready_q) begin
            rvalid_d = 1'b1;
            rresp_d  = resp_for(ar_idx_s);
            rdata_d  = is_mapped(ar_idx_s) ? regs_q[ar_idx_s[1:0]] : {DW{1'b0}};
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end

        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;
        arready_d = ~rvalid_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
            aw_held_q <= 1'b0;
            aw_idx_q  <= {IDX_W{1'b0}};
            w_held_q  <= 1'b0;
            wdata_q   <= {DW{1'b0}};
            wstrb_q   <= {SW{1'b0}};
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DW{1'b0}};
            rresp_q   <= 2'b00;
            pulse_q   <= 4'b0000;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            pulse_q   <= pulse_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign reg0_o          = regs_q[0];
    assign reg1_o          = regs_q[1];
    assign reg2_o          = regs_q[2];
    assign reg3_o          = regs_q[3];
    assign reg_wr_pulse_o  = pulse_q;

endmodule
